// File: rtl/mips_fetch_stage_if.sv
// Bus between the MIPS fetch stage and its surroundings: the instruction ROM,
// the hazard/redirect controls, and the IF/ID pipeline register outputs.
// FETCH_PERF_CNT_EN adds the fetch/bubble performance counter outputs.
interface mips_fetch_stage_if;
    logic [11:0] rom_addr;
    logic [31:0] rom_data;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    // Fetch stage side
    modport master (
        output rom_addr, pc, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_err,
`ifdef FETCH_PERF_CNT_EN
        output fetch_count, bubble_count,
`endif
        input  rom_data, stall, flush, redirect_valid, redirect_target, halt_req, resume
    );

    // ROM / pipeline control side
    modport slave (
        input  rom_addr, pc, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_err,
`ifdef FETCH_PERF_CNT_EN
        input  fetch_count, bubble_count,
`endif
        output rom_data, stall, flush, redirect_valid, redirect_target, halt_req, resume
    );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, addresses the combinational
// instruction ROM and registers the returned word into IF/ID.
// States RUN / HALTED / ERROR; a misaligned redirect is a sticky error.
// Optional: define FETCH_PERF_CNT_EN for fetch_count / bubble_count outputs.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    mips_fetch_stage_if.master bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 12;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_ERROR  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              fetch_err_q, fetch_err_d;
    logic [XLEN-1:0]   pc_plus4;
    logic              load_bubble;
    logic              load_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0]   bubble_cnt_q, bubble_cnt_d;
`endif

    assign pc_plus4 = pc_q + XLEN'(4);

    // Next-state, next-PC and IF/ID load decision
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        load_bubble = 1'b0;
        load_valid  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_d     = ST_HALTED;
                    load_bubble = 1'b1;
                end else if (bus.redirect_valid) begin
                    load_bubble = 1'b1;
                    if (bus.redirect_target[1:0] != 2'b00) begin
                        state_d = ST_ERROR;
                    end else begin
                        pc_d = bus.redirect_target;
                    end
                end else if (bus.stall) begin
                    // Hold everything; a concurrent flush still squashes IF/ID
                    load_bubble = bus.flush;
                end else begin
                    pc_d        = pc_plus4;
                    load_bubble = bus.flush;
                    load_valid  = ~bus.flush;
                end
            end
            ST_HALTED: begin
                load_bubble = 1'b1;
                if (bus.resume) begin
                    state_d = ST_RUN;
                end
            end
            ST_ERROR: begin
                load_bubble = 1'b1;
            end
            default: begin
                state_d     = ST_RUN;
                load_bubble = 1'b1;
            end
        endcase

        if (load_bubble) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (load_valid) begin
            instr_d = bus.rom_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end

        halted_d    = (state_d != ST_RUN);
        fetch_err_d = fetch_err_q | (state_d == ST_ERROR);
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters; pure stall-hold edges count in neither
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + XLEN'(load_valid);
        bubble_cnt_d = bubble_cnt_q + XLEN'(load_bubble && (state_q == ST_RUN));
    end
`endif

    // State and pipeline registers, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_WORD;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
            fetch_err_q  <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            halted_q     <= halted_d;
            fetch_err_q  <= fetch_err_d;
`ifdef FETCH_PERF_CNT_EN
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
`endif
        end
    end

    assign bus.rom_addr    = pc_q[AW-1:0];
    assign bus.pc          = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.if_id_valid = valid_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_err   = fetch_err_q;
`ifdef FETCH_PERF_CNT_EN
    assign bus.fetch_count  = fetch_cnt_q;
    assign bus.bubble_count = bubble_cnt_q;
`endif
endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline, directly upstream of the instruction ROM.
- Owns the PC and drives the ROM's 12-bit byte address. The ROM returns the 32-bit word combinationally in the same cycle.
- Registers that word into the IF/ID pipeline register for decode.
- Handles stall, flush, branch/jump redirect, halt and misaligned-target error.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_WORD, 32'h0000_0000, instruction word loaded into IF/ID for bubbles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_addr  out  12  byte address to the ROM; always equals pc[11:0].
- rom_data  in  32  instruction word from the ROM, combinational from rom_addr.
- stall  in  1  hold PC and IF/ID (load-use hazard from decode).
- flush  in  1  load a bubble into IF/ID this edge.
- redirect_valid  in  1  branch/jump taken; PC takes redirect_target.
- redirect_target  in  32  new PC.
- halt_req  in  1  program exit (syscall); stop fetching.
- resume  in  1  leave HALTED state.
- pc  out  32  current fetch PC.
- if_id_instr  out  32  registered instruction.
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped, HALTED state.
- fetch_err  out  1  sticky; misaligned redirect seen, ERROR state.

Behaviour:
- Reset (async, immediate on assertion):
  - pc=RESET_PC; if_id_instr=NOP_WORD; if_id_pc4=0; if_id_valid=0; halted=0; fetch_err=0; state=RUN.
- Latency: instruction at pc appears on if_id_instr one edge later. No ROM wait states.
- States: RUN, HALTED, ERROR. State is encoded in 2 bits; the unused code returns to RUN.
- RUN, per rising edge. Priority is halt_req > redirect_valid > stall > normal:
  - halt_req=1: go to HALTED. pc holds. IF/ID gets a bubble (valid=0, instr=NOP_WORD). A redirect in the same cycle is ignored.
  - redirect_valid=1 with redirect_target[1:0]!=0: go to ERROR. Set fetch_err. pc holds. IF/ID gets a bubble.
  - redirect_valid=1, aligned: pc<=redirect_target. IF/ID gets a bubble, because the wrong-path fetch is squashed. Redirect overrides stall.
  - stall=1 (no redirect): pc and IF/ID hold all values. If flush=1 in the same cycle, flush wins for IF/ID only: IF/ID gets a bubble and pc still holds.
  - normal: pc<=pc+4; if_id_instr<=rom_data; if_id_pc4<=pc+4; if_id_valid<=1. If flush=1, IF/ID gets a bubble instead and pc still advances.
- HALTED:
  - halted=1; pc frozen; IF/ID gets a bubble every edge. stall, flush and redirect are ignored.
  - resume=1: go to RUN; fetch restarts at the held pc on the next edge.
- ERROR:
  - fetch_err=1, halted=1. Left only by rst; resume is ignored.
- Arithmetic:
  - pc+4 is 32-bit modular; 32'hFFFF_FFFC wraps to 0.
  - rom_addr uses pc[11:0] only, so the PC aliases modulo 4 KiB (1024 words). No range error is raised.
- Mid-operation reset: all registers return to reset values in the same instant, independent of clk. The first fetch after deassertion is at RESET_PC.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, add two outputs:
  - fetch_count (32): increments on every edge where IF/ID loads a valid instruction.
  - bubble_count (32): increments on every edge where IF/ID loads a bubble while in RUN.
- Both counters reset to 0 and wrap modulo 2^32. Stall-hold cycles count in neither counter.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then 4 free-running edges, ROM word = address-tagged pattern -> pc 0,4,8,C,10. if_id_instr follows the word at 0,4,8,C one edge behind; if_id_pc4 4,8,C,10; valid=1 from the first edge.
- At pc=8, stall=1 for 2 cycles -> pc stays 8 and IF/ID holds the word from 4 for both cycles. Raise flush during the stall -> valid=0 with pc still 8.
- At pc=10, redirect_valid=1 with target 0x40, stall=1 simultaneously -> next pc=0x40, valid=0. The following edge loads the word at 0x40 with pc4=0x44.
- Redirect target 0x42 -> fetch_err=1, halted=1, pc unchanged. resume has no effect; rst clears it.
- halt_req at pc=0x20 -> halted=1, pc frozen at 0x20 for 5 edges, valid=0. resume -> next fetched word is from 0x20.
- Set pc to 0xFFC via redirect, run 1 edge -> pc=0x1000, rom_addr=0x000. Assert rst mid-cycle -> outputs reset immediately, without waiting for clk.
- With FETCH_PERF_CNT_EN defined, 3 valid loads + 1 redirect + 2 stall cycles -> fetch_count=3, bubble_count=1.
